instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage upstream of the instruction decoder. It reads one 32-bit word per instruction from
//  instruction memory and holds it stable on ir. It pulses cs to launch the decoder, then waits for
//  the decoder's ready1 to drop (acknowledge) and rise again (done). Only then does it advance pc,
//  either sequentially or to a branch target, and fetch the next instruction.
// PARAMETERS
//  ADDR_W    16             width of pc / mem_addr
//  PC_INC    1              pc increment per instruction (word addressing)
//  RESET_PC  0              pc value after reset
//  CNT_W     16             width of retired-instruction counter
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  en         in   1        run enable; low parks the stage in IDLE after the current instruction
//  mem_rd     out  1        instruction memory read request
//  mem_addr   out  ADDR_W   instruction address (equals pc)
//  mem_rdata  in   32       instruction word, valid when mem_ready=1
//  mem_ready  in   1        memory data valid / read complete
//  ir         out  32       instruction register to decoder
//  cs         out  1        decoder launch strobe (one-cycle pulse)
//  ready1     in   1        decoder ready/done flag
//  br_valid   in   1        branch redirect request, sampled at retire
//  br_target  in   ADDR_W   redirect address
//  pc         out  ADDR_W   address of instruction currently held in ir
//  busy       out  1        high in every state except IDLE
//  retired    out  CNT_W    count of completed instructions
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=mem_addr=RESET_PC, ir=0, cs=0, mem_rd=0, busy=0, retired=0.
//  All outputs are registered. mem_addr is always equal to pc.
//  FSM states: IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE.
//   IDLE:      en=1 -> FETCH on the next edge.
//   FETCH:     mem_rd=1. At an edge with mem_ready=1: ir<=mem_rdata, mem_rd<=0, go ISSUE.
//              Otherwise hold. Minimum latency is 1 cycle, since mem_ready may be high in the first FETCH cycle.
//   ISSUE:     cs=1 for exactly one cycle, then WAIT_ACK.
//   WAIT_ACK:  ready1=0 -> WAIT_DONE; ready1=1 -> hold. Waits for the decoder to leave its idle state.
//   WAIT_DONE: ready1=1 -> retire:
//              - retired<=retired+1, wrapping modulo 2^CNT_W;
//              - pc<=br_valid ? br_target : pc+PC_INC, wrapping modulo 2^ADDR_W;
//              - next state is FETCH if en=1, else IDLE.
//  ir is stable from ISSUE until the next FETCH completes.
//  pc changes only at retire, never mid-instruction.
//  en is sampled only in IDLE and at retire. Deasserting en mid-instruction never aborts the instruction.
//  br_valid/br_target are ignored outside the retire cycle.
//  If br_valid=1 and pc+PC_INC also wraps in the same cycle, the branch wins.
//  Reset mid-operation: immediate return to reset values, including in FETCH with mem_rd high.
//  Any pending memory response after reset is ignored, because the FSM is in IDLE.
//  cs is never asserted while the FSM is in FETCH/WAIT_ACK/WAIT_DONE. There is no back-to-back cs.
// TESTING
//  1 Reset: hold rst_n=0 with en=1, mem_ready=1 -> pc=0, cs=0, mem_rd=0, busy=0, retired=0
//    throughout; first mem_rd 2 cycles after rst_n rises.
//  2 Sequential: memory returns in 1 cycle, decoder model drops ready1 1 cycle after cs and raises
//    it 3 cycles later; run 4 instrs -> mem_addr 0,1,2,3; one cs pulse each; retired=4.
//  3 Memory wait: mem_ready held low 5 cycles with mem_rdata=32'h0030_0000 -> mem_rd high all
//    5 cycles; ir=32'h0030_0000 loaded only on the mem_ready edge; cs follows next cycle.
//  4 Branch: pc=5, br_valid=1, br_target=16'h0040 at retire -> next mem_addr=16'h0040.
//    Also br_valid=1 outside retire -> no effect.
//  5 Wrap: RESET_PC=16'hFFFF, no branch -> after retire pc=16'h0000.
//    retired preset near max wraps to 0.
//  6 Halt/reset mid-op: en=0 during WAIT_DONE -> instruction retires, then IDLE, busy=0.
//    rst_n pulsed low during FETCH -> mem_rd falls immediately, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetches one word per instruction, launches the decoder with a
// one-cycle cs strobe, and advances pc only after the decoder acknowledges and completes.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                PC_INC   = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       ir,
  output logic              cs,
  input  logic              ready1,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t state;

  assign mem_addr = pc;

  // Outputs are updated on the transition into the state that owns them, so each is a plain flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      cs      <= 1'b0;
      mem_rd  <= 1'b0;
      busy    <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state  <= FETCH;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            ir     <= mem_rdata;
            mem_rd <= 1'b0;
            cs     <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          cs    <= 1'b0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!ready1) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (ready1) begin
            retired <= retired + CNT_W'(1);
            pc      <= br_valid ? br_target : pc + ADDR_W'(PC_INC);
            if (en) begin
              state  <= FETCH;
              mem_rd <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          cs     <= 1'b0;
          mem_rd <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
